// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package muldiv_pkg;

    // Operand widths up to this value are supported by twos_neg.
    localparam int MAX_WIDTH = 64;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DZERO = 2'd3
    } state_e;

    // Two's-complement negation; callers zero-extend into and truncate out of
    // MAX_WIDTH, which gives the correct modulo-2^WIDTH result.
    function automatic logic [MAX_WIDTH-1:0] twos_neg(input logic [MAX_WIDTH-1:0] v);
        return ~v + MAX_WIDTH'(1);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Start/done handshake and operand/result bus of the multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b,
                    input  busy, done, div_zero, hi, lo);
    modport slave  (input  start, op, a, b,
                    output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and restoring divide sharing one
// shift-register pair; one bit per cycle, sign fixup in a final cycle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; operands and signs captured on start
// ST_CALC  | WIDTH iterations of shift-add or restoring subtract
// ST_FIXUP | apply result signs, write hi/lo, pulse done
// ST_DZERO | divide by zero: pulse done with div_zero, hi/lo untouched
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    // acc_hi: product upper half / partial remainder
    // acc_lo: multiplier then product lower half / dividend then quotient
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    // multiplicand or divisor magnitude
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    // Next-state, datapath iteration and registered-output computation.
    always_comb begin
        logic               in_div;
        logic               in_signed;
        logic [WIDTH-1:0]   a_mag;
        logic [WIDTH-1:0]   b_mag;
        logic [WIDTH:0]     sum_m;
        logic [WIDTH:0]     shifted;
        logic [2*WIDTH-1:0] prod;

        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        opb_d      = opb_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        in_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
        in_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        a_mag     = (in_signed && bus.a[WIDTH-1]) ? WIDTH'(twos_neg(MAX_WIDTH'(bus.a))) : bus.a;
        b_mag     = (in_signed && bus.b[WIDTH-1]) ? WIDTH'(twos_neg(MAX_WIDTH'(bus.b))) : bus.b;

        sum_m   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opb_q : '0)};
        // One more bit than the divisor so the shifted remainder never overflows.
        shifted = {acc_hi_q, acc_lo_q[WIDTH-1]};
        prod    = {acc_hi_q, acc_lo_q};

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (in_div && (bus.b == '0)) begin
                        state_d = ST_DZERO;
                    end else begin
                        state_d   = ST_CALC;
                        cnt_d     = '0;
                        is_div_d  = in_div;
                        neg_res_d = in_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_rem_d = in_signed && in_div && bus.a[WIDTH-1];
                        acc_hi_d  = '0;
                        acc_lo_d  = in_div ? a_mag : b_mag;
                        opb_d     = in_div ? b_mag : a_mag;
                    end
                end
            end
            ST_CALC: begin
                if (is_div_q) begin
                    if (shifted >= {1'b0, opb_q}) begin
                        acc_hi_d = WIDTH'(shifted - {1'b0, opb_q});
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = shifted[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_hi_d = sum_m[WIDTH:1];
                    acc_lo_d = {sum_m[0], acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                if (is_div_q) begin
                    lo_d = neg_res_q ? WIDTH'(twos_neg(MAX_WIDTH'(acc_lo_q))) : acc_lo_q;
                    hi_d = neg_rem_q ? WIDTH'(twos_neg(MAX_WIDTH'(acc_hi_q))) : acc_hi_q;
                end else begin
                    if (neg_res_q) begin
                        prod = ~prod + (2*WIDTH)'(1);
                    end
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                done_d     = 1'b1;
                div_zero_d = 1'b0;
                state_d    = ST_IDLE;
            end
            ST_DZERO: begin
                done_d     = 1'b1;
                div_zero_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            opb_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            opb_q      <= opb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) bus32 ();
    muldiv_if #(.WIDTH(8))  bus8 ();

    muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Launch an op on the 32-bit unit and wait (bounded) for done.
    // lat = edges from the start-sampling edge to the edge raising done.
    // disturb pulses a different start and changes operands mid-CALC.
    task automatic go32(input bit align, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit disturb,
                        output int lat, output int bcyc);
        int l = 0;
        int bc = 0;
        if (align) @(negedge clk);
        bus32.start = 1'b1;
        bus32.op    = op;
        bus32.a     = a;
        bus32.b     = b;
        @(negedge clk);
        bus32.start = 1'b0;
        while (!bus32.done && l < 100) begin
            if (bus32.busy) bc++;
            if (disturb && l == 5) begin
                bus32.start = 1'b1;
                bus32.op    = OP_DIVU;
                bus32.a     = 32'd100;
                bus32.b     = 32'd7;
            end
            if (disturb && l == 6) bus32.start = 1'b0;
            @(negedge clk);
            l++;
        end
        lat  = l;
        bcyc = bc;
    endtask

    task automatic go8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       output int lat);
        int l = 0;
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.op    = op;
        bus8.a     = a;
        bus8.b     = b;
        @(negedge clk);
        bus8.start = 1'b0;
        while (!bus8.done && l < 100) begin
            @(negedge clk);
            l++;
        end
        lat = l;
    endtask

    initial begin
        int lat;
        int bc;
        int dn;

        reset       = 1'b1;
        bus32.start = 1'b0;
        bus32.op    = OP_MULT;
        bus32.a     = '0;
        bus32.b     = '0;
        bus8.start  = 1'b0;
        bus8.op     = OP_MULT;
        bus8.a      = '0;
        bus8.b      = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_busy", 64'(bus32.busy), 64'd0);
        chk("rst_done", 64'(bus32.done), 64'd0);
        chk("rst_dz",   64'(bus32.div_zero), 64'd0);
        chk("rst_hilo", {bus32.hi, bus32.lo}, 64'd0);

        go32(1'b1, OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, lat, bc);
        chk("mult_lat",  64'(lat), 64'd33);
        chk("mult_hilo", {bus32.hi, bus32.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mult_dz",   64'(bus32.div_zero), 64'd0);

        go32(1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bc);
        chk("multu_busy", 64'(bc), 64'd33);
        chk("multu_hilo", {bus32.hi, bus32.lo}, 64'hFFFF_FFFE_0000_0001);
        chk("multu_busy_done", 64'(bus32.busy), 64'd0);
        @(negedge clk);
        chk("done_pulse", 64'(bus32.done), 64'd0);

        go32(1'b1, OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 1'b0, lat, bc);
        chk("mult_negneg", {bus32.hi, bus32.lo}, 64'h0000_0000_0000_001E);

        go32(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, bc);
        chk("div_lat",  64'(lat), 64'd33);
        chk("div_hilo", {bus32.hi, bus32.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        go32(1'b1, OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, lat, bc);
        chk("div_posneg", {bus32.hi, bus32.lo}, 64'h0000_0001_FFFF_FFFD);

        go32(1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, bc);
        chk("div_ovf_hilo", {bus32.hi, bus32.lo}, 64'h0000_0000_8000_0000);
        chk("div_ovf_dz",   64'(bus32.div_zero), 64'd0);

        go32(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0, lat, bc);
        chk("divu_hilo", {bus32.hi, bus32.lo}, 64'h0000_0002_0000_000E);

        go32(1'b1, OP_DIVU, 32'd5, 32'd0, 1'b0, lat, bc);
        chk("dz_lat",  64'(lat), 64'd1);
        chk("dz_busy", 64'(bc), 64'd1);
        chk("dz_flag", 64'(bus32.div_zero), 64'd1);
        chk("dz_hilo", {bus32.hi, bus32.lo}, 64'h0000_0002_0000_000E);
        @(negedge clk);
        chk("dz_hold", {63'd0, bus32.div_zero}, 64'd1);

        go32(1'b1, OP_DIV, 32'hFFFF_FFF0, 32'd0, 1'b0, lat, bc);
        chk("dz_signed", {bus32.div_zero, 31'd0, bus32.lo}, {1'b1, 31'd0, 32'h0000_000E});

        go32(1'b1, OP_MULTU, 32'd3, 32'd4, 1'b1, lat, bc);
        chk("ignore_lat",  64'(lat), 64'd33);
        chk("ignore_hilo", {bus32.hi, bus32.lo}, 64'd12);
        chk("ignore_dz",   64'(bus32.div_zero), 64'd0);

        go32(1'b0, OP_MULTU, 32'd6, 32'd7, 1'b0, lat, bc);
        chk("b2b_lat",  64'(lat), 64'd33);
        chk("b2b_hilo", {bus32.hi, bus32.lo}, 64'd42);

        @(negedge clk);
        bus32.start = 1'b1;
        bus32.op    = OP_MULT;
        bus32.a     = 32'd123;
        bus32.b     = 32'd456;
        @(negedge clk);
        bus32.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", 64'(bus32.busy), 64'd0);
        chk("midrst_done", 64'(bus32.done), 64'd0);
        chk("midrst_hilo", {bus32.hi, bus32.lo}, 64'd0);
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus32.done) dn++;
        end
        chk("midrst_nodone", 64'(dn), 64'd0);

        go32(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0, lat, bc);
        chk("recover_hilo", {bus32.hi, bus32.lo}, 64'h0000_0002_0000_000E);

        go8(OP_MULTU, 8'hFF, 8'hFF, lat);
        chk("w8_lat",  64'(lat), 64'd9);
        chk("w8_hilo", {48'd0, bus8.hi, bus8.lo}, 64'h0000_0000_0000_FE01);

        go8(OP_DIV, 8'h80, 8'hFF, lat);
        chk("w8_div_ovf", {48'd0, bus8.hi, bus8.lo}, 64'h0000_0000_0000_0080);

        go8(OP_DIV, 8'hF9, 8'h02, lat);
        chk("w8_div", {48'd0, bus8.hi, bus8.lo}, 64'h0000_0000_0000_FFFD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
